// File: rtl/pipelined_md_controller.sv
// pipelined_md_controller
// Registered RV32IM decode/control stage between the IF/ID and ID/EX pipeline
// registers. Ordinary instructions are decoded and presented one cycle later.
// M-extension ops with a latency above one hold the pipe in MD_WAIT until
// their result slot arrives.

module pipelined_md_controller #(
   parameter int MUL_CYCLES = 2,
   parameter int DIV_CYCLES = 33,
   parameter int ALU_OP_W   = 5
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic                IN_VALID,
   input  logic [6:0]          OPCODE,
   input  logic [2:0]          FUNC3,
   input  logic [6:0]          FUNC7,
   input  logic                STALL_IN,
   input  logic                FLUSH,
   output logic                STALL_OUT,
   output logic                OUT_VALID,
   output logic                ILLEGAL,
   output logic                MD_BUSY,
   output logic                REG_WRITE_EN,
   output logic                MEM_READ_EN,
   output logic                MEM_WRITE_EN,
   output logic                COMP_SEL,
   output logic                OP1_SEL,
   output logic                OP2_SEL,
   output logic [1:0]          WB_VALUE_SEL,
   output logic [1:0]          BJ_CTRL,
   output logic [2:0]          IMM_SEL,
   output logic [ALU_OP_W-1:0] ALU_OP,
   output logic [2:0]          MEM_FUNC3
);

   localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   // The counter is loaded with L-2: the capture edge and the release edge
   // account for two of the L cycles.
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'((DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] F7_MEXT    = 7'b0000001;

   typedef enum logic [0:0] {
      S_IDLE    = 1'b0,
      S_MD_WAIT = 1'b1
   } state_t;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       comp_sel;
      logic       op1_sel;
      logic       op2_sel;
      logic [1:0] wb_sel;
      logic [1:0] bj_ctrl;
      logic [2:0] imm_sel;
      logic [4:0] alu_op;
   } ctrl_t;

   state_t           r_state, w_next_state;
   logic [CNT_W-1:0] r_cnt, w_next_cnt;
   logic [CNT_W-1:0] w_md_load;
   ctrl_t            r_ctrl, w_dec;
   logic [2:0]       r_mem_func3;
   logic             r_out_valid, w_next_valid;
   logic             r_md_busy, w_next_busy;
   logic             r_illegal, w_next_illegal;
   logic             w_dec_illegal;
   logic             w_is_mop;
   logic             w_md_long;
   logic             w_capture;

   // Combinational decode of the instruction fields into the control bundle.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      w_dec         = '0;
      w_dec_illegal = 1'b0;
      case (OPCODE)
         OPC_LUI: begin
            w_dec.reg_write = 1'b1;
            w_dec.imm_sel   = 3'd0;
            w_dec.alu_op    = 5'b11111;
         end
         OPC_AUIPC: begin
            w_dec.reg_write = 1'b1;
            w_dec.op1_sel   = 1'b1;
            w_dec.op2_sel   = 1'b1;
            w_dec.imm_sel   = 3'd3;
         end
         OPC_JAL: begin
            w_dec.reg_write = 1'b1;
            w_dec.wb_sel    = 2'd2;
            w_dec.bj_ctrl   = 2'd1;
            w_dec.op1_sel   = 1'b1;
            w_dec.op2_sel   = 1'b1;
            w_dec.imm_sel   = 3'd1;
         end
         OPC_JALR: begin
            w_dec.reg_write = 1'b1;
            w_dec.wb_sel    = 2'd2;
            w_dec.bj_ctrl   = 2'd1;
            w_dec.op2_sel   = 1'b1;
            w_dec.imm_sel   = 3'd4;
         end
         OPC_BRANCH: begin
            w_dec.bj_ctrl  = 2'd2;
            w_dec.comp_sel = 1'b1;
            w_dec.imm_sel  = 3'd2;
         end
         OPC_LOAD: begin
            w_dec.mem_read  = 1'b1;
            w_dec.reg_write = 1'b1;
            w_dec.wb_sel    = 2'd1;
            w_dec.op2_sel   = 1'b1;
            w_dec.imm_sel   = 3'd4;
         end
         OPC_STORE: begin
            w_dec.mem_write = 1'b1;
            w_dec.op2_sel   = 1'b1;
            w_dec.imm_sel   = 3'd2;
         end
         OPC_OPIMM: begin
            w_dec.reg_write = 1'b1;
            w_dec.op2_sel   = 1'b1;
            w_dec.imm_sel   = 3'd4;
            // Only the shift-right immediates use FUNC7[5] (SRLI vs SRAI).
            w_dec.alu_op    = {1'b0, (FUNC3 == 3'b101) ? FUNC7[5] : 1'b0, FUNC3};
         end
         OPC_OP: begin
            w_dec.reg_write = 1'b1;
            w_dec.alu_op    = {FUNC7[0], FUNC7[5], FUNC3};
            w_dec.comp_sel  = FUNC7[5] & ~FUNC3[0] & ~FUNC7[0];
         end
         default: w_dec_illegal = 1'b1;
      endcase
   end

   // M-op classification: FUNC3[2] separates the divide group from the multiply group.
   assign w_is_mop  = (OPCODE == OPC_OP) && (FUNC7 == F7_MEXT);
   assign w_md_long = w_is_mop && (FUNC3[2] ? (DIV_CYCLES > 1) : (MUL_CYCLES > 1));
   assign w_md_load = FUNC3[2] ? DIV_LOAD : MUL_LOAD;

   // Next-state and next-output logic; FLUSH outranks STALL_IN, which outranks capture.
   always_comb begin
      w_next_state   = r_state;
      w_next_cnt     = r_cnt;
      w_next_valid   = r_out_valid;
      w_next_busy    = r_md_busy;
      w_next_illegal = r_illegal;
      w_capture      = 1'b0;
      if (FLUSH) begin
         w_next_state   = S_IDLE;
         w_next_cnt     = '0;
         w_next_valid   = 1'b0;
         w_next_busy    = 1'b0;
         w_next_illegal = 1'b0;
      end else if (!STALL_IN) begin
         case (r_state)
            S_IDLE: begin
               w_next_valid = IN_VALID;
               if (IN_VALID) begin
                  w_capture      = 1'b1;
                  w_next_illegal = w_dec_illegal;
                  if (w_md_long) begin
                     w_next_valid = 1'b0;
                     w_next_busy  = 1'b1;
                     w_next_cnt   = w_md_load;
                     w_next_state = S_MD_WAIT;
                  end
               end
            end
            S_MD_WAIT: begin
               if (r_cnt != '0) begin
                  w_next_cnt = r_cnt - 1'b1;
               end else begin
                  w_next_valid = 1'b1;
                  w_next_busy  = 1'b0;
                  w_next_state = S_IDLE;
               end
            end
            default: w_next_state = S_IDLE;
         endcase
      end
   end

   // Sequencer state register and latency counter.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
      end
   end

   // Output registers; the control fields only load on a capture and otherwise hold.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_out_valid <= 1'b0;
         r_md_busy   <= 1'b0;
         r_illegal   <= 1'b0;
         r_ctrl      <= '0;
         r_mem_func3 <= '0;
      end else begin
         r_out_valid <= w_next_valid;
         r_md_busy   <= w_next_busy;
         r_illegal   <= w_next_illegal;
         if (w_capture) begin
            r_ctrl      <= w_dec;
            r_mem_func3 <= FUNC3;
         end
      end
   end

   assign STALL_OUT    = STALL_IN | (r_state == S_MD_WAIT);
   assign OUT_VALID    = r_out_valid;
   assign ILLEGAL      = r_illegal;
   assign MD_BUSY      = r_md_busy;
   assign REG_WRITE_EN = r_ctrl.reg_write;
   assign MEM_READ_EN  = r_ctrl.mem_read;
   assign MEM_WRITE_EN = r_ctrl.mem_write;
   assign COMP_SEL     = r_ctrl.comp_sel;
   assign OP1_SEL      = r_ctrl.op1_sel;
   assign OP2_SEL      = r_ctrl.op2_sel;
   assign WB_VALUE_SEL = r_ctrl.wb_sel;
   assign BJ_CTRL      = r_ctrl.bj_ctrl;
   assign IMM_SEL      = r_ctrl.imm_sel;
   assign ALU_OP       = ALU_OP_W'(r_ctrl.alu_op);
   assign MEM_FUNC3    = r_mem_func3;

endmodule

// File: tb/tb_pipelined_md_controller.sv
// tb_pipelined_md_controller
// Scenario tasks drive instructions and push the expected control bundle into
// a scoreboard queue. The queue is popped and compared whenever the DUT
// presents OUT_VALID.

module tb_pipelined_md_controller;

   localparam int MUL_CYC = 2;
   localparam int DIV_CYC = 33;
   localparam int ALU_W   = 5;

   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] OPIMM  = 7'b0010011;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] SYS    = 7'b1110011;

   logic             CLK = 1'b0;
   logic             RESET_N = 1'b0;
   logic             IN_VALID = 1'b0;
   logic [6:0]       OPCODE = '0;
   logic [2:0]       FUNC3 = '0;
   logic [6:0]       FUNC7 = '0;
   logic             STALL_IN = 1'b0;
   logic             FLUSH = 1'b0;
   logic             STALL_OUT, OUT_VALID, ILLEGAL, MD_BUSY;
   logic             REG_WRITE_EN, MEM_READ_EN, MEM_WRITE_EN, COMP_SEL, OP1_SEL, OP2_SEL;
   logic [1:0]       WB_VALUE_SEL, BJ_CTRL;
   logic [2:0]       IMM_SEL, MEM_FUNC3;
   logic [ALU_W-1:0] ALU_OP;

   // {ILLEGAL, RW, MR, MW, COMP, OP1, OP2, WB[1:0], BJ[1:0], IMM[2:0], ALU[4:0], MEM_FUNC3[2:0]}
   typedef logic [21:0] bundle_t;

   bundle_t sb_q[$];
   int      n_checks = 0;
   int      n_fail   = 0;

   pipelined_md_controller #(
      .MUL_CYCLES(MUL_CYC),
      .DIV_CYCLES(DIV_CYC),
      .ALU_OP_W  (ALU_W)
   ) dut (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .IN_VALID    (IN_VALID),
      .OPCODE      (OPCODE),
      .FUNC3       (FUNC3),
      .FUNC7       (FUNC7),
      .STALL_IN    (STALL_IN),
      .FLUSH       (FLUSH),
      .STALL_OUT   (STALL_OUT),
      .OUT_VALID   (OUT_VALID),
      .ILLEGAL     (ILLEGAL),
      .MD_BUSY     (MD_BUSY),
      .REG_WRITE_EN(REG_WRITE_EN),
      .MEM_READ_EN (MEM_READ_EN),
      .MEM_WRITE_EN(MEM_WRITE_EN),
      .COMP_SEL    (COMP_SEL),
      .OP1_SEL     (OP1_SEL),
      .OP2_SEL     (OP2_SEL),
      .WB_VALUE_SEL(WB_VALUE_SEL),
      .BJ_CTRL     (BJ_CTRL),
      .IMM_SEL     (IMM_SEL),
      .ALU_OP      (ALU_OP),
      .MEM_FUNC3   (MEM_FUNC3)
   );

   always #5 CLK = ~CLK;

   // Reference decode table, written straight from the instruction-class list.
   function automatic bundle_t model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      logic       ill, rw, mr, mw, cmp, o1, o2;
      logic [1:0] wb, bj;
      logic [2:0] imm;
      logic [4:0] alu;
      ill = 0; rw = 0; mr = 0; mw = 0; cmp = 0; o1 = 0; o2 = 0;
      wb = 0; bj = 0; imm = 0; alu = 0;
      case (op)
         LUI:    begin rw = 1; imm = 0; alu = 5'b11111; end
         AUIPC:  begin rw = 1; o1 = 1; o2 = 1; imm = 3; end
         JAL:    begin rw = 1; wb = 2; bj = 1; o1 = 1; o2 = 1; imm = 1; end
         JALR:   begin rw = 1; wb = 2; bj = 1; o2 = 1; imm = 4; end
         BRANCH: begin bj = 2; cmp = 1; imm = 2; end
         LOAD:   begin mr = 1; rw = 1; wb = 1; o2 = 1; imm = 4; end
         STORE:  begin mw = 1; o2 = 1; imm = 2; end
         OPIMM: begin
            rw = 1; o2 = 1; imm = 4;
            alu = {2'b00, f3};
            if (f3 == 3'b101) alu[3] = f7[5];
         end
         OP: begin
            rw = 1;
            alu = {f7[0], f7[5], f3};
            cmp = f7[5] && (f3[0] == 1'b0) && (f7[0] == 1'b0);
         end
         default: ill = 1;
      endcase
      return {ill, rw, mr, mw, cmp, o1, o2, wb, bj, imm, alu, f3};
   endfunction

   function automatic int latency(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      if (op == OP && f7 == 7'b0000001) return f3[2] ? DIV_CYC : MUL_CYC;
      return 1;
   endfunction

   function automatic bundle_t observed();
      return {ILLEGAL, REG_WRITE_EN, MEM_READ_EN, MEM_WRITE_EN, COMP_SEL, OP1_SEL, OP2_SEL,
              WB_VALUE_SEL, BJ_CTRL, IMM_SEL, ALU_OP[4:0], MEM_FUNC3};
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Present fields without expecting a capture (ignored or flushed inputs).
   task automatic set_instr(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      IN_VALID = v;
      OPCODE   = op;
      FUNC3    = f3;
      FUNC7    = f7;
   endtask

   // Present an instruction that will be captured and record its expected bundle.
   task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      set_instr(1'b1, op, f3, f7);
      sb_q.push_back(model(op, f3, f7));
   endtask

   task automatic test_reset();
      bundle_t got;
      RESET_N = 1'b0;
      set_instr(1'b1, OP, 3'b100, 7'b0000001);
      tick();
      tick();
      got = observed();
      n_checks++;
      if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", OUT_VALID); end
      n_checks++;
      if (MD_BUSY !== 1'b0 || STALL_OUT !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy_stall: got busy=%b stall_out=%b expected 0 0", MD_BUSY, STALL_OUT);
      end
      n_checks++;
      if (got !== '0) begin n_fail++; $display("FAIL reset_bundle: got %h expected 000000", got); end
      set_instr(1'b0, '0, '0, '0);
      RESET_N = 1'b1;
      tick();
   endtask

   task automatic test_addi();
      bundle_t got, exp;
      issue(OPIMM, 3'b000, 7'b0000000);
      tick();
      set_instr(1'b0, '0, '0, '0);
      got = observed();
      exp = sb_q.pop_front();
      n_checks++;
      if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b expected 1", OUT_VALID); end
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL addi_bundle: got %h expected %h", got, exp); end
      n_checks++;
      if ({REG_WRITE_EN, OP2_SEL, IMM_SEL, ALU_OP, STALL_OUT} !== {1'b1, 1'b1, 3'd4, 5'b00000, 1'b0}) begin
         n_fail++; $display("FAIL addi_fields: got rw=%b op2=%b imm=%0d alu=%b stall_out=%b expected 1 1 4 00000 0",
                            REG_WRITE_EN, OP2_SEL, IMM_SEL, ALU_OP, STALL_OUT);
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] ops[11] = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, OPIMM, OPIMM, OP, OP, OP};
      logic [2:0] f3s[11] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b101, 3'b101, 3'b100, 3'b010, 3'b000};
      logic [6:0] f7s[11] = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00};
      bundle_t got, exp;
      for (int i = 0; i < 11; i++) begin
         issue(ops[i], f3s[i], f7s[i]);
         tick();
         got = observed();
         exp = sb_q.pop_front();
         n_checks++;
         if (OUT_VALID !== 1'b1 || got !== exp) begin
            n_fail++; $display("FAIL b2b_%0d: got valid=%b bundle=%h expected valid=1 bundle=%h", i, OUT_VALID, got, exp);
         end
      end
      set_instr(1'b0, '0, '0, '0);
      tick();
      n_checks++;
      if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_valid: got %b expected 0", OUT_VALID); end
   endtask

   task automatic test_sub_sw();
      bundle_t got, exp;
      issue(OP, 3'b000, 7'b0100000);
      tick();
      got = observed();
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp || ALU_OP !== 5'b01000 || COMP_SEL !== 1'b1) begin
         n_fail++; $display("FAIL sub: got bundle=%h alu=%b comp=%b expected bundle=%h alu=01000 comp=1", got, ALU_OP, COMP_SEL, exp);
      end
      issue(STORE, 3'b010, 7'b0000000);
      tick();
      set_instr(1'b0, '0, '0, '0);
      got = observed();
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp || {MEM_WRITE_EN, REG_WRITE_EN, IMM_SEL, MEM_FUNC3} !== {1'b1, 1'b0, 3'd2, 3'b010}) begin
         n_fail++; $display("FAIL sw: got bundle=%h mw=%b rw=%b imm=%0d f3=%b expected bundle=%h 1 0 2 010",
                            got, MEM_WRITE_EN, REG_WRITE_EN, IMM_SEL, MEM_FUNC3, exp);
      end
   endtask

   // Issue one M-op, optionally assert STALL_IN for stall_len cycles starting
   // stall_at cycles after capture, and check latency, busy window and result.
   task automatic run_md(input string name, input logic [2:0] f3, input int stall_at, input int stall_len);
      bundle_t got, exp, snap;
      int      lat, cnt, wait_cycles, bad;
      lat = latency(OP, f3, 7'b0000001);
      issue(OP, f3, 7'b0000001);
      tick();
      cnt = 1; wait_cycles = 0; bad = 0;
      snap = observed();
      // Inputs must be ignored while the sequencer is busy.
      set_instr(1'b1, OP, 3'b000, 7'b0000000);
      while (OUT_VALID !== 1'b1 && cnt < 200) begin
         if (STALL_OUT !== 1'b1 || MD_BUSY !== 1'b1 || observed() !== snap) bad++;
         wait_cycles++;
         STALL_IN = (cnt >= stall_at) && (cnt < stall_at + stall_len);
         tick();
         cnt++;
      end
      STALL_IN = 1'b0;
      set_instr(1'b0, '0, '0, '0);
      #1;
      got = observed();
      exp = sb_q.pop_front();
      n_checks++;
      if (cnt !== lat + stall_len) begin
         n_fail++; $display("FAIL %s_latency: got %0d cycles expected %0d", name, cnt, lat + stall_len);
      end
      n_checks++;
      if (wait_cycles !== lat - 1 + stall_len || bad !== 0) begin
         n_fail++; $display("FAIL %s_busy_window: got %0d cycles, %0d bad expected %0d cycles, 0 bad",
                            name, wait_cycles, bad, lat - 1 + stall_len);
      end
      n_checks++;
      if (got !== exp || MD_BUSY !== 1'b0 || STALL_OUT !== 1'b0) begin
         n_fail++; $display("FAIL %s_result: got bundle=%h busy=%b stall_out=%b expected bundle=%h busy=0 stall_out=0",
                            name, got, MD_BUSY, STALL_OUT, exp);
      end
      tick();
   endtask

   task automatic test_md_latency();
      run_md("div", 3'b100, 0, 0);
      n_checks++;
      if (sb_q.size() !== 0) begin n_fail++; $display("FAIL div_queue: got %0d pending expected 0", sb_q.size()); end
      run_md("mul", 3'b000, 0, 0);
      run_md("mulhu", 3'b011, 0, 0);
      run_md("remu", 3'b111, 0, 0);
   endtask

   task automatic test_stall();
      bundle_t got, exp, snap;
      run_md("div_stall", 3'b100, 4, 3);
      // Back-pressure in IDLE: the visible result and the bundle both hold.
      issue(OP, 3'b000, 7'b0000000);
      tick();
      got = observed();
      exp = sb_q.pop_front();
      n_checks++;
      if (OUT_VALID !== 1'b1 || got !== exp) begin
         n_fail++; $display("FAIL stall_add: got valid=%b bundle=%h expected valid=1 bundle=%h", OUT_VALID, got, exp);
      end
      snap = got;
      STALL_IN = 1'b1;
      set_instr(1'b1, STORE, 3'b001, 7'b0000000);
      tick();
      tick();
      n_checks++;
      if (OUT_VALID !== 1'b1 || observed() !== snap || STALL_OUT !== 1'b1) begin
         n_fail++; $display("FAIL stall_idle_hold: got valid=%b bundle=%h stall_out=%b expected valid=1 bundle=%h stall_out=1",
                            OUT_VALID, observed(), STALL_OUT, snap);
      end
      STALL_IN = 1'b0;
      issue(STORE, 3'b001, 7'b0000000);
      tick();
      set_instr(1'b0, '0, '0, '0);
      got = observed();
      exp = sb_q.pop_front();
      n_checks++;
      if (OUT_VALID !== 1'b1 || got !== exp) begin
         n_fail++; $display("FAIL stall_release_sh: got valid=%b bundle=%h expected valid=1 bundle=%h", OUT_VALID, got, exp);
      end
   endtask

   task automatic test_flush();
      bundle_t got, exp;
      issue(OP, 3'b100, 7'b0000001);
      tick();
      set_instr(1'b0, '0, '0, '0);
      for (int i = 0; i < 4; i++) tick();
      FLUSH = 1'b1;
      tick();
      FLUSH = 1'b0;
      #1;
      void'(sb_q.pop_front());
      n_checks++;
      if (OUT_VALID !== 1'b0 || MD_BUSY !== 1'b0 || STALL_OUT !== 1'b0) begin
         n_fail++; $display("FAIL flush_div: got valid=%b busy=%b stall_out=%b expected 0 0 0", OUT_VALID, MD_BUSY, STALL_OUT);
      end
      issue(OP, 3'b000, 7'b0000000);
      tick();
      got = observed();
      exp = sb_q.pop_front();
      n_checks++;
      if (OUT_VALID !== 1'b1 || got !== exp) begin
         n_fail++; $display("FAIL flush_add_after: got valid=%b bundle=%h expected valid=1 bundle=%h", OUT_VALID, got, exp);
      end
      // FLUSH together with a valid instruction wins over the capture.
      FLUSH = 1'b1;
      set_instr(1'b1, SYS, 3'b000, 7'b0000000);
      tick();
      FLUSH = 1'b0;
      set_instr(1'b0, '0, '0, '0);
      n_checks++;
      if (OUT_VALID !== 1'b0 || ILLEGAL !== 1'b0) begin
         n_fail++; $display("FAIL flush_vs_capture: got valid=%b illegal=%b expected 0 0", OUT_VALID, ILLEGAL);
      end
   endtask

   task automatic test_illegal_and_reset();
      bundle_t got, exp;
      issue(SYS, 3'b000, 7'b0000000);
      tick();
      set_instr(1'b0, '0, '0, '0);
      got = observed();
      exp = sb_q.pop_front();
      n_checks++;
      if (OUT_VALID !== 1'b1 || ILLEGAL !== 1'b1 || got !== exp) begin
         n_fail++; $display("FAIL illegal: got valid=%b illegal=%b bundle=%h expected 1 1 %h", OUT_VALID, ILLEGAL, got, exp);
      end
      n_checks++;
      if (got[20:3] !== '0) begin n_fail++; $display("FAIL illegal_controls: got %h expected 0", got[20:3]); end
      // Reset in the middle of a divide takes effect before the next clock edge.
      issue(OP, 3'b110, 7'b0000001);
      tick();
      set_instr(1'b0, '0, '0, '0);
      tick();
      tick();
      RESET_N = 1'b0;
      #1;
      got = observed();
      n_checks++;
      if (OUT_VALID !== 1'b0 || MD_BUSY !== 1'b0 || STALL_OUT !== 1'b0 || got !== '0) begin
         n_fail++; $display("FAIL async_reset: got valid=%b busy=%b stall_out=%b bundle=%h expected 0 0 0 000000",
                            OUT_VALID, MD_BUSY, STALL_OUT, got);
      end
      sb_q.delete();
      tick();
      RESET_N = 1'b1;
      for (int i = 0; i < 40; i++) tick();
      n_checks++;
      if (OUT_VALID !== 1'b0 || STALL_OUT !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_quiet: got valid=%b stall_out=%b expected 0 0", OUT_VALID, STALL_OUT);
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_back_to_back();
      test_sub_sw();
      test_md_latency();
      test_stall();
      test_flush();
      test_illegal_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pipelined_md_controller.md
Name: pipelined_md_controller

Overview:
- Registered RV32IM decode/control stage sitting between the IF/ID and ID/EX pipeline registers.
- Decodes OPCODE/FUNC3/FUNC7 into the standard control bundle and presents it one cycle later with a valid flag.
- Adds a multi-cycle sequencer for M-extension ops: parametrised MUL/DIV latencies, an upstream stall, downstream back-pressure, flush, and illegal-opcode flagging.

Parameters:
- MUL_CYCLES, 2, execute cycles for MUL/MULH/MULHSU/MULHU; must be >=1.
- DIV_CYCLES, 33, execute cycles for DIV/DIVU/REM/REMU; must be >=1.
- ALU_OP_W, 5, ALU_OP width; must be >=5.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  instruction fields valid this cycle.
- OPCODE  in  7  instruction[6:0].
- FUNC3  in  3  instruction[14:12].
- FUNC7  in  7  instruction[31:25].
- STALL_IN  in  1  downstream cannot accept; hold all outputs.
- FLUSH  in  1  kill registered and in-flight instruction.
- STALL_OUT  out  1  upstream must hold the instruction (comb).
- OUT_VALID  out  1  control bundle valid.
- ILLEGAL  out  1  registered: captured opcode unsupported.
- MD_BUSY  out  1  M-op sequencing in progress.
- REG_WRITE_EN, MEM_READ_EN, MEM_WRITE_EN, COMP_SEL, OP1_SEL, OP2_SEL  out  1 each  registered controls.
- WB_VALUE_SEL  out  2  0=ALU, 1=MEM, 2=PC+4.
- BJ_CTRL  out  2  0=none, 1=jump, 2=branch.
- IMM_SEL  out  3  immediate format select.
- ALU_OP  out  ALU_OP_W  ALU operation; upper bits zero.
- MEM_FUNC3  out  3  registered FUNC3 for load/store width.

Behaviour:
- Reset (async, RESET_N=0): state IDLE, counter 0, every registered output 0.
- Decode table (all unlisted controls 0):
  - LUI: RW=1, IMM=0, ALU_OP=5'b11111.
  - AUIPC: RW=1, OP1=OP2=1, IMM=3, ALU=0.
  - JAL: RW=1, WB=2, BJ=1, OP1=OP2=1, IMM=1.
  - JALR: RW=1, WB=2, BJ=1, OP2=1, IMM=4.
  - BRANCH: BJ=2, COMP=1, IMM=2.
  - LOAD: MR=1, RW=1, WB=1, OP2=1, IMM=4.
  - STORE: MW=1, OP2=1, IMM=2; RW=0.
  - OP-IMM: RW=1, OP2=1, IMM=4, ALU={0, FUNC3==101 ? FUNC7[5] : 0, FUNC3}.
  - OP: RW=1, ALU={FUNC7[0], FUNC7[5], FUNC3}, COMP=(FUNC7[5] & ~FUNC3[0] & ~FUNC7[0]).
  - Other opcodes: all controls 0, ILLEGAL=1, OUT_VALID=1.
- M-op: OPCODE=0110011 and FUNC7=0000001. Latency L = MUL_CYCLES if FUNC3[2]=0, else DIV_CYCLES.
- States: IDLE, MD_WAIT.
- IDLE, STALL_IN=0:
  - Capture decode into output registers when IN_VALID=1; OUT_VALID<=IN_VALID.
  - Non-M op: latency 1 cycle (inputs at edge N appear after edge N).
  - M-op with L=1: same as non-M op.
  - M-op with L>1: OUT_VALID<=0, controls captured, counter<=L-2, go to MD_WAIT, MD_BUSY<=1.
- MD_WAIT:
  - STALL_OUT=1; inputs ignored.
  - Counter decrements each cycle while >0.
  - When counter==0 and STALL_IN=0: OUT_VALID<=1, MD_BUSY<=0, go to IDLE.
  - The M-op is therefore visible L cycles after capture.
- STALL_IN=1: all registered outputs, state and counter hold (counter also freezes in MD_WAIT).
- STALL_OUT = STALL_IN | (state==MD_WAIT), combinational.
- FLUSH=1 (priority over STALL_IN and capture): OUT_VALID<=0, ILLEGAL<=0, MD_BUSY<=0, go to IDLE, counter<=0. Control fields may hold stale values but are qualified by OUT_VALID.
- Reset mid-MD_WAIT: immediate return to reset values; no partial output.
- IN_VALID=0 in IDLE: OUT_VALID<=0, other fields don't care (hold).
- Counter width: $clog2(max(MUL_CYCLES,DIV_CYCLES)+1); it never underflows.

Test Plan:
- Reset then ADDI (OP-IMM, FUNC3=000), IN_VALID=1 -> next cycle OUT_VALID=1, RW=1, OP2=1, IMM=4, ALU=5'b00000, STALL_OUT=0.
- SUB (OP, FUNC7=0100000, FUNC3=000) then SW -> cycle 1: ALU=5'b01000, COMP=1; cycle 2: MW=1, RW=0, IMM=2, MEM_FUNC3=010.
- DIV (FUNC7=0000001, FUNC3=100), DIV_CYCLES=33 -> STALL_OUT=1 and MD_BUSY=1 for 32 cycles, OUT_VALID=1 with ALU=5'b10100 exactly 33 cycles after capture; MUL with MUL_CYCLES=2 -> OUT_VALID 2 cycles after capture.
- STALL_IN=1 for 3 cycles during MD_WAIT -> counter frozen, result OUT_VALID delayed by exactly 3 cycles; outputs stable during the stall.
- FLUSH at cycle 5 of a DIV -> next cycle OUT_VALID=0, MD_BUSY=0, STALL_OUT=0; a following ADD decodes normally.
- OPCODE=1110011 -> OUT_VALID=1, ILLEGAL=1, all controls 0; RESET_N low mid-sequence -> outputs 0 asynchronously, before the next clock edge.
